tick_generator: RTL and testbench

Multi-channel, runtime-programmable clock-enable generator replacing fixed free-running divided clocks. Each of `N_CH` channels counts `clk_in` cycles against its own divisor and produces a single-cycle `tick` enable and a near-50% square wave `sq`. Everything stays in the `clk_in` domain, so downstream timer, display-scan and buzzer logic uses `tick` as an enable, not as a clock. Divisor changes are glitch-free and take effect only at a period boundary.

---
 rtl/tick_generator_if.sv | 35 +++
 rtl/tick_generator.sv | 104 ++++++++++
 tb/tb_tick_generator.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tick_generator_if.sv
// tick_generator_if: control and output bundle for tick_generator.
//   ch_en        master->slave  per-channel run enable
//   sync_restart master->slave  realign every channel to phase 0
//   cfg_wr       master->slave  divisor write strobe
//   cfg_ch       master->slave  target channel of the write
//   cfg_div      master->slave  new full period in clock cycles
//   cfg_ack      slave->master  one-cycle pulse, write accepted
//   cfg_err      slave->master  one-cycle pulse, write rejected
//   tick         slave->master  one-cycle enable per channel period
//   sq           slave->master  per-channel square wave
interface tick_generator_if #(
   parameter int unsigned N_CH  = 4,
   parameter int unsigned DIV_W = 26,
   parameter int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
);
   logic [N_CH-1:0]  ch_en;
   logic             sync_restart;
   logic             cfg_wr;
   logic [CH_W-1:0]  cfg_ch;
   logic [DIV_W-1:0] cfg_div;
   logic             cfg_ack;
   logic             cfg_err;
   logic [N_CH-1:0]  tick;
   logic [N_CH-1:0]  sq;

   modport master (
      output ch_en, sync_restart, cfg_wr, cfg_ch, cfg_div,
      input  cfg_ack, cfg_err, tick, sq
   );

   modport slave (
      input  ch_en, sync_restart, cfg_wr, cfg_ch, cfg_div,
      output cfg_ack, cfg_err, tick, sq
   );
endinterface

// File: rtl/tick_generator.sv
// tick_generator: multi-channel, runtime-programmable clock-enable generator. Each channel counts
// clk_in cycles against its own divisor and emits a one-cycle tick plus a near-50% square wave.
// Divisor writes are staged as pending and only take effect at a period boundary, a restart or
// while the channel is disabled, so no runt period is ever produced.
//   clk_in  system clock
//   reset   synchronous, active-high reset
//   bus     tick_generator_if.slave: ch_en, sync_restart, cfg_wr/cfg_ch/cfg_div in;
//           cfg_ack, cfg_err, tick, sq out (all registered)
module tick_generator #(
   parameter int unsigned            CLK_HZ   = 40000000,
   parameter int unsigned            N_CH     = 4,
   parameter int unsigned            DIV_W    = 26,
   parameter logic [N_CH*DIV_W-1:0]  INIT_DIV = {26'd20000, 26'd40000, 26'd80000, 26'd40000000}
) (
   input logic             clk_in,
   input logic             reset,
   tick_generator_if.slave bus
);

   if (N_CH < 1 || N_CH > 16 || CLK_HZ == 0) begin : g_param_check
      $error("tick_generator: N_CH must be 1..16 and CLK_HZ non-zero");
   end

   logic [N_CH-1:0][DIV_W-1:0] cnt_q, cnt_d;
   logic [N_CH-1:0][DIV_W-1:0] div_act_q, div_act_d;
   logic [N_CH-1:0][DIV_W-1:0] div_pend_q, div_pend_d;
   logic [N_CH-1:0]            pend_v_q, pend_v_d;
   logic [N_CH-1:0]            tick_q, tick_d;
   logic [N_CH-1:0]            sq_q, sq_d;
   logic                       cfg_ack_q, cfg_ack_d;
   logic                       cfg_err_q, cfg_err_d;
   logic                       cfg_ok;
   logic [N_CH-1:0]            wrap;

   always_comb begin
      cfg_ok     = bus.cfg_wr && (bus.cfg_div >= DIV_W'(2)) &&
                   (int'(bus.cfg_ch) < int'(N_CH));
      cfg_ack_d  = cfg_ok;
      cfg_err_d  = bus.cfg_wr && !cfg_ok;
      cnt_d      = cnt_q;
      div_act_d  = div_act_q;
      div_pend_d = div_pend_q;
      pend_v_d   = pend_v_q;
      tick_d     = '0;
      sq_d       = '0;
      wrap       = '0;

      for (int i = 0; i < int'(N_CH); i++) begin
         wrap[i] = bus.ch_en[i] && (cnt_q[i] == div_act_q[i] - DIV_W'(1));

         if (bus.sync_restart || !bus.ch_en[i]) begin
            cnt_d[i] = '0;
         end else if (wrap[i]) begin
            cnt_d[i]  = '0;
            tick_d[i] = 1'b1;
         end else begin
            cnt_d[i] = cnt_q[i] + DIV_W'(1);
         end

         // A pending divisor is safe to adopt whenever the count restarts from zero.
         if ((bus.sync_restart || !bus.ch_en[i] || wrap[i]) && pend_v_q[i]) begin
            div_act_d[i] = div_pend_q[i];
            pend_v_d[i]  = 1'b0;
         end

         // Evaluated after the apply so a same-edge write survives as the next pending value.
         if (cfg_ok && (int'(bus.cfg_ch) == i)) begin
            div_pend_d[i] = bus.cfg_div;
            pend_v_d[i]   = 1'b1;
         end

         // Register the comparison of the next count so sq lines up with cnt cycle by cycle.
         sq_d[i] = bus.ch_en[i] && !bus.sync_restart && (cnt_d[i] >= (div_act_d[i] >> 1));
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         cnt_q      <= '0;
         div_act_q  <= INIT_DIV;
         div_pend_q <= '0;
         pend_v_q   <= '0;
         tick_q     <= '0;
         sq_q       <= '0;
         cfg_ack_q  <= 1'b0;
         cfg_err_q  <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         div_act_q  <= div_act_d;
         div_pend_q <= div_pend_d;
         pend_v_q   <= pend_v_d;
         tick_q     <= tick_d;
         sq_q       <= sq_d;
         cfg_ack_q  <= cfg_ack_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   assign bus.tick    = tick_q;
   assign bus.sq      = sq_q;
   assign bus.cfg_ack = cfg_ack_q;
   assign bus.cfg_err = cfg_err_q;

endmodule

// File: tb/tb_tick_generator.sv
// tb_tick_generator: self-checking bench for tick_generator. Expected tick vectors for a test
// window are pushed into a queue up front and popped one per cycle as the DUT runs.
module tb_tick_generator;
   localparam int unsigned N_CH  = 4;
   localparam int unsigned DIV_W = 26;
   localparam logic [N_CH*DIV_W-1:0] INIT = {26'd2, 26'd10, 26'd5, 26'd4};
   localparam int unsigned N3 = 3;
   localparam logic [N3*DIV_W-1:0] INIT3 = {26'd3, 26'd3, 26'd3};

   logic clk_in = 1'b0;
   logic reset;
   always #5 clk_in = ~clk_in;

   tick_generator_if #(.N_CH(N_CH), .DIV_W(DIV_W)) bus ();
   tick_generator_if #(.N_CH(N3), .DIV_W(DIV_W)) bus3 ();

   tick_generator #(
      .CLK_HZ(100000000), .N_CH(N_CH), .DIV_W(DIV_W), .INIT_DIV(INIT)
   ) dut (
      .clk_in(clk_in), .reset(reset), .bus(bus)
   );

   tick_generator #(
      .CLK_HZ(100000000), .N_CH(N3), .DIV_W(DIV_W), .INIT_DIV(INIT3)
   ) dut3 (
      .clk_in(clk_in), .reset(reset), .bus(bus3)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [N_CH-1:0] exp_q[$];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle_inputs();
      bus.ch_en         = '1;
      bus.sync_restart  = 1'b0;
      bus.cfg_wr        = 1'b0;
      bus.cfg_ch        = '0;
      bus.cfg_div       = '0;
      bus3.ch_en        = '1;
      bus3.sync_restart = 1'b0;
      bus3.cfg_wr       = 1'b0;
      bus3.cfg_ch       = '0;
      bus3.cfg_div      = '0;
   endtask

   // Leaves the bench inside cycle 0: state freshly reset, reset now low.
   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic exp_init(input int n);
      exp_q.delete();
      repeat (n) exp_q.push_back('0);
   endtask

   task automatic exp_add(input int ch, input int first, input int period, input int last);
      logic [N_CH-1:0] v;
      for (int c = first; c <= last && c < exp_q.size(); c += period) begin
         v = exp_q[c];
         v[ch] = 1'b1;
         exp_q[c] = v;
      end
   endtask

   task automatic cfg_write(input int ch, input int div);
      bus.cfg_wr  = 1'b1;
      bus.cfg_ch  = 2'(ch);
      bus.cfg_div = DIV_W'(div);
   endtask

   task automatic test_reset();
      idle_inputs();
      cfg_write(1, 7);
      bus.sync_restart = 1'b1;
      reset = 1'b1;
      step();
      step();
      n_cmp++;
      if ({bus.tick, bus.sq} !== '0) begin
         n_bad++;
         $display("FAIL reset_tick_sq: got %b, want 0", {bus.tick, bus.sq});
      end
      n_cmp++;
      if ({bus.cfg_ack, bus.cfg_err} !== 2'b00) begin
         n_bad++;
         $display("FAIL reset_ack_err: got %b, want 00", {bus.cfg_ack, bus.cfg_err});
      end
      n_cmp++;
      if ({bus3.tick, bus3.sq, bus3.cfg_ack, bus3.cfg_err} !== '0) begin
         n_bad++;
         $display("FAIL reset_dut3: got %b, want 0",
                  {bus3.tick, bus3.sq, bus3.cfg_ack, bus3.cfg_err});
      end
      idle_inputs();
   endtask

   task automatic test_defaults();
      logic [N_CH-1:0] e;
      do_reset();
      exp_init(26);
      exp_add(0, 4, 4, 25);
      exp_add(1, 5, 5, 25);
      exp_add(2, 10, 10, 25);
      exp_add(3, 2, 2, 25);
      for (int t = 0; t < 26; t++) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (bus.tick !== e) begin
            n_bad++;
            $display("FAIL defaults_tick c%0d: got %b, want %b", t, bus.tick, e);
         end
         n_cmp++;
         if (bus.sq[1] !== ((t % 5) >= 2)) begin
            n_bad++;
            $display("FAIL defaults_sq1 c%0d: got %b, want %b", t, bus.sq[1], (t % 5) >= 2);
         end
         n_cmp++;
         if (bus.sq[0] !== ((t % 4) >= 2)) begin
            n_bad++;
            $display("FAIL defaults_sq0 c%0d: got %b, want %b", t, bus.sq[0], (t % 4) >= 2);
         end
         step();
      end
   endtask

   // ch0 div 4 -> 6; with pre_div != 0 an earlier write one cycle before is overwritten.
   task automatic test_div_change(input int wr_t, input int pre_div);
      logic [N_CH-1:0] e;
      logic            ack_e;
      do_reset();
      exp_init(30);
      exp_add(0, 4, 4, 8);
      exp_add(0, 14, 6, 29);
      for (int t = 0; t < 30; t++) begin
         e = exp_q.pop_front();
         ack_e = (t == wr_t + 1) || (pre_div != 0 && t == wr_t);
         n_cmp++;
         if (bus.tick[0] !== e[0]) begin
            n_bad++;
            $display("FAIL div_change(wr@%0d) tick0 c%0d: got %b, want %b",
                     wr_t, t, bus.tick[0], e[0]);
         end
         n_cmp++;
         if ({bus.cfg_ack, bus.cfg_err} !== {ack_e, 1'b0}) begin
            n_bad++;
            $display("FAIL div_change(wr@%0d) ack/err c%0d: got %b, want %b",
                     wr_t, t, {bus.cfg_ack, bus.cfg_err}, {ack_e, 1'b0});
         end
         if (pre_div != 0 && t == wr_t - 1) cfg_write(0, pre_div);
         else if (t == wr_t) cfg_write(0, 6);
         else bus.cfg_wr = 1'b0;
         step();
      end
   endtask

   task automatic test_cfg_err();
      logic [N_CH-1:0] e;
      logic [1:0]      ae;
      do_reset();
      exp_init(24);
      exp_add(0, 4, 4, 23);
      exp_add(1, 5, 5, 23);
      exp_add(2, 10, 10, 23);
      exp_add(3, 2, 2, 23);
      for (int t = 0; t < 24; t++) begin
         e  = exp_q.pop_front();
         ae = (t == 3 || t == 4) ? 2'b01 : (t == 5) ? 2'b10 : 2'b00;
         n_cmp++;
         if (bus.tick !== e) begin
            n_bad++;
            $display("FAIL cfg_err_tick c%0d: got %b, want %b", t, bus.tick, e);
         end
         n_cmp++;
         if ({bus.cfg_ack, bus.cfg_err} !== ae) begin
            n_bad++;
            $display("FAIL cfg_err_ackerr c%0d: got %b, want %b",
                     t, {bus.cfg_ack, bus.cfg_err}, ae);
         end
         if (t == 2) cfg_write(0, 1);
         else if (t == 3) cfg_write(1, 0);
         else if (t == 4) cfg_write(3, 2);
         else bus.cfg_wr = 1'b0;
         step();
      end
   endtask

   task automatic test_bad_channel();
      logic [N3-1:0] te;
      do_reset();
      for (int t = 0; t < 13; t++) begin
         te = (t > 0 && (t % 3) == 0) ? '1 : '0;
         n_cmp++;
         if (bus3.tick !== te) begin
            n_bad++;
            $display("FAIL bad_channel_tick c%0d: got %b, want %b", t, bus3.tick, te);
         end
         n_cmp++;
         if ({bus3.cfg_ack, bus3.cfg_err} !== {1'b0, t == 2}) begin
            n_bad++;
            $display("FAIL bad_channel_err c%0d: got %b, want %b",
                     t, {bus3.cfg_ack, bus3.cfg_err}, {1'b0, t == 2});
         end
         if (t == 1) begin
            bus3.cfg_wr  = 1'b1;
            bus3.cfg_ch  = 2'd3;
            bus3.cfg_div = DIV_W'(5);
         end else begin
            bus3.cfg_wr = 1'b0;
         end
         step();
      end
   endtask

   task automatic test_disable();
      logic [N_CH-1:0] e;
      int              ph;
      do_reset();
      exp_init(36);
      exp_add(2, 22, 10, 35);
      for (int t = 0; t < 36; t++) begin
         e  = exp_q.pop_front();
         ph = (t <= 7) ? t : (t <= 12) ? 0 : (t - 12) % 10;
         n_cmp++;
         if (bus.tick[2] !== e[2]) begin
            n_bad++;
            $display("FAIL disable_tick2 c%0d: got %b, want %b", t, bus.tick[2], e[2]);
         end
         n_cmp++;
         if (bus.sq[2] !== (ph >= 5)) begin
            n_bad++;
            $display("FAIL disable_sq2 c%0d: got %b, want %b", t, bus.sq[2], ph >= 5);
         end
         if (t == 7) bus.ch_en[2] = 1'b0;
         if (t == 12) bus.ch_en[2] = 1'b1;
         step();
      end
   endtask

   task automatic test_sync_restart();
      logic [N_CH-1:0] e;
      do_reset();
      exp_init(26);
      exp_add(0, 4, 4, 4);
      exp_add(0, 12, 6, 25);
      exp_add(1, 5, 5, 5);
      exp_add(1, 11, 3, 25);
      exp_add(2, 18, 10, 25);
      exp_add(3, 2, 2, 6);
      exp_add(3, 10, 2, 25);
      for (int t = 0; t < 26; t++) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (bus.tick !== e) begin
            n_bad++;
            $display("FAIL sync_tick c%0d: got %b, want %b", t, bus.tick, e);
         end
         n_cmp++;
         if (bus.cfg_ack !== (t == 6 || t == 8)) begin
            n_bad++;
            $display("FAIL sync_ack c%0d: got %b, want %b", t, bus.cfg_ack, t == 6 || t == 8);
         end
         if (t == 8) begin
            n_cmp++;
            if (bus.sq !== '0) begin
               n_bad++;
               $display("FAIL sync_sq_zero c%0d: got %b, want 0", t, bus.sq);
            end
         end
         if (t >= 8) begin
            n_cmp++;
            if (bus.sq[1] !== (((t - 8) % 3) >= 1)) begin
               n_bad++;
               $display("FAIL sync_sq1 c%0d: got %b, want %b", t, bus.sq[1], ((t - 8) % 3) >= 1);
            end
         end
         bus.sync_restart = (t == 7);
         if (t == 5) cfg_write(1, 3);
         else if (t == 7) cfg_write(0, 6);
         else bus.cfg_wr = 1'b0;
         step();
      end
   endtask

   task automatic test_reset_mid();
      logic [N_CH-1:0] e;
      do_reset();
      exp_init(30);
      exp_add(0, 4, 4, 8);
      exp_add(0, 14, 4, 29);
      exp_add(1, 5, 5, 5);
      exp_add(1, 15, 5, 29);
      exp_add(2, 20, 10, 29);
      exp_add(3, 2, 2, 8);
      exp_add(3, 12, 2, 29);
      for (int t = 0; t < 30; t++) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (bus.tick !== e) begin
            n_bad++;
            $display("FAIL reset_mid_tick c%0d: got %b, want %b", t, bus.tick, e);
         end
         n_cmp++;
         if (bus.cfg_ack !== (t == 9)) begin
            n_bad++;
            $display("FAIL reset_mid_ack c%0d: got %b, want %b", t, bus.cfg_ack, t == 9);
         end
         if (t == 10) begin
            n_cmp++;
            if ({bus.sq, bus.cfg_err} !== '0) begin
               n_bad++;
               $display("FAIL reset_mid_zero c%0d: got %b, want 0", t, {bus.sq, bus.cfg_err});
            end
         end
         if (t == 8) cfg_write(0, 6);
         else bus.cfg_wr = 1'b0;
         reset = (t == 9);
         step();
      end
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_defaults();
      test_div_change(5, 9);
      test_div_change(3, 0);
      test_cfg_err();
      test_bad_channel();
      test_disable();
      test_sync_restart();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
